// File: rtl/alu_responder.sv
// alu_responder: single-operation ALU with valid/ready request and response
// handshakes. One operation is in flight at a time: IDLE -> EXEC -> RESP.
module alu_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_control,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic        resp_err,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  ctl_q;
    logic [31:0] alu_res;
    logic        alu_err;
    logic        accept;
    logic        handshake;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        handshake  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    handshake = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ALU operating only on the captured operands
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ctl_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: alu_res = a_q + b_q;
            3'b011: alu_res = a_q ^ b_q;
            3'b100: alu_res = ~(a_q | b_q);
            3'b110: alu_res = a_q - b_q;
            3'b111: alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
            default: alu_err = 1'b1;
        endcase
    end

    // Operand capture on request acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            ctl_q <= '0;
        end else if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            ctl_q <= req_control;
        end
    end

    // Response registers, loaded once on leaving EXEC and held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else if (state == EXEC) begin
            resp_result <= alu_res;
            resp_zero   <= (alu_res == '0);
            resp_err    <= alu_err;
        end
    end

    // Completed-handshake counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (handshake) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: table-driven checks of alu_responder with an expected-
// response queue, plus hand sequences for backpressure, input hold,
// request-while-busy and mid-operation reset.
module tb_alu_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_control;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic        resp_err;
    logic [15:0] op_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    vec_t        vecs[12];
    exp_t        exp_q[$];
    int          total;
    int          bad;
    logic [15:0] exp_cnt;

    alu_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_control (req_control),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream never returns
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, optionally stall the response, then complete it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                          input logic [31:0] er, input logic ez, input logic ee,
                          input int stall, input bit keep_valid, output int waits);
        exp_t e;
        req_a       = a;
        req_b       = b;
        req_control = ctl;
        req_valid   = 1'b1;
        resp_ready  = 1'b0;
        waits       = 0;
        while (req_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        exp_q.push_back('{res: er, zero: ez, err: ee});
        if (!keep_valid) req_valid = 1'b0;
        req_a       = ~a;
        req_b       = b ^ 32'h5A5A_5A5A;
        req_control = ctl ^ 3'b011;
        check("exec_resp_valid", 32'(resp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("resp_valid_latency", 32'(resp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q[0];
        for (int i = 0; i < stall; i++) begin
            check("stall_result", resp_result, e.res);
            check("stall_zero", 32'(resp_zero), 32'(e.zero));
            check("stall_err", 32'(resp_err), 32'(e.err));
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_count", 32'(op_count), 32'(exp_cnt));
            @(posedge clk); #1;
        end
        check("resp_valid_held", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        e = exp_q.pop_front();
        check("result", resp_result, e.res);
        check("zero", 32'(resp_zero), 32'(e.zero));
        check("err", 32'(resp_err), 32'(e.err));
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_cnt++;
        check("op_count", 32'(op_count), 32'(exp_cnt));
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("post_resp_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int waits;
        total = 0;
        bad   = 0;
        exp_cnt = '0;

        vecs[0]  = '{32'hA, 32'h7, 3'b011, 32'hD,         1'b0, 1'b0};
        vecs[1]  = '{32'hA, 32'h7, 3'b100, 32'hFFFFFFF0,  1'b0, 1'b0};
        vecs[2]  = '{32'hA, 32'h7, 3'b010, 32'h11,        1'b0, 1'b0};
        vecs[3]  = '{32'hA, 32'h7, 3'b111, 32'h0,         1'b1, 1'b0};
        vecs[4]  = '{32'hA, 32'h7, 3'b110, 32'h3,         1'b0, 1'b0};
        vecs[5]  = '{32'hA, 32'h7, 3'b001, 32'hF,         1'b0, 1'b0};
        vecs[6]  = '{32'hA, 32'h7, 3'b000, 32'h2,         1'b0, 1'b0};
        vecs[7]  = '{32'hA, 32'h7, 3'b101, 32'h0,         1'b1, 1'b1};
        vecs[8]  = '{32'h1, 32'h2, 3'b010, 32'h3,         1'b0, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'h0, 3'b111, 32'h1,  1'b0, 1'b0};
        vecs[10] = '{32'h0, 32'hFFFFFFFF, 3'b111, 32'h0,  1'b1, 1'b0};
        vecs[11] = '{32'h80000000, 32'h1, 3'b111, 32'h1,  1'b0, 1'b0};

        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        req_a       = '0;
        req_b       = '0;
        req_control = '0;
        rst_n       = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_result", resp_result, 32'd0);
        check("rst_zero", 32'(resp_zero), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Vector table: ALUOp sweep, illegal code recovery, signed SLT
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].res, vecs[i].zero,
                   vecs[i].err, i % 3, 1'b0, waits);
            if (i == 6) check("sweep_op_count", 32'(op_count), 32'd7);
        end

        // Backpressure: wrapping ADD held for five cycles
        run_op(32'hFFFFFFFF, 32'h1, 3'b010, 32'h0, 1'b1, 1'b0, 5, 1'b0, waits);

        // req_valid held through EXEC/RESP; next accept at the edge after handshake
        run_op(32'h0000_00F0, 32'h0000_000F, 3'b001, 32'hFF, 1'b0, 1'b0, 2, 1'b1, waits);
        run_op(32'h0000_0009, 32'h0000_0004, 3'b110, 32'h5, 1'b0, 1'b0, 0, 1'b0, waits);
        check("b2b_accept_waits", 32'(waits), 32'd0);

        // Reset while in EXEC: operation discarded, nothing appears afterwards
        req_a = 32'h1234; req_b = 32'h1; req_control = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("exec_before_rst", 32'(resp_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("exec_rst_req_ready", 32'(req_ready), 32'd1);
        check("exec_rst_count", 32'(op_count), 32'd0);
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("exec_rst_no_resp", 32'(resp_valid), 32'd0);
        end

        // Reset while in RESP
        run_op(32'h3, 32'h4, 3'b010, 32'h7, 1'b0, 1'b0, 0, 1'b0, waits);
        req_a = 32'hFFFF_FFFF; req_b = 32'h1234; req_control = 3'b000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("resp_before_rst", 32'(resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_result", resp_result, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        run_op(32'h5, 32'h5, 3'b110, 32'h0, 1'b1, 1'b0, 0, 1'b0, waits);
        check("post_rst_count", 32'(op_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_responder.md
ALU_RESPONDER -- requirements
Module: alu_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: the initiator presents an operation.
REQ-004 SHALL have port req_ready, output, 1 bit: the block can accept an operation.
REQ-005 SHALL have port req_a, input, 32 bits: operand A.
REQ-006 SHALL have port req_b, input, 32 bits: operand B.
REQ-007 SHALL have port req_control, input, 3 bits: ALUOp code.
REQ-008 SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-009 SHALL have port resp_ready, input, 1 bit: the initiator takes the response.
REQ-010 SHALL have port resp_result, output, 32 bits: the ALU result.
REQ-011 SHALL have port resp_zero, output, 1 bit: 1 when resp_result == 0.
REQ-012 SHALL have port resp_err, output, 1 bit: an illegal ALUOp was received.
REQ-013 SHALL have port op_count, output, 16 bits: the number of completed response handshakes.

Function
REQ-014 SHALL use FSM states IDLE, EXEC and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-015 SHALL accept a request when IDLE, req_valid = 1 and req_ready = 1: capture req_a, req_b and req_control into internal registers, then go to EXEC.
REQ-016 SHALL, in EXEC, compute from the captured operands only, register resp_result, resp_zero and resp_err on the next edge, and go to RESP.
REQ-016a SHALL give a latency of 2 edges: request accepted at edge N -> resp_valid = 1 after edge N+1.
REQ-017 SHALL decode ALUOp as: 000 AND; 001 OR; 010 ADD (mod 2^32, carry discarded); 011 XOR; 100 NOR; 110 SUB A-B (mod 2^32); 111 SLT (signed A<B -> 32'd1, else 32'd0).
REQ-018 SHALL treat ALUOp 101 as illegal: resp_result = 0, resp_zero = 1, resp_err = 1.
REQ-018a SHALL drive resp_err = 0 for every legal code.
REQ-019 SHALL, in RESP, hold resp_result, resp_zero and resp_err stable while resp_ready = 0, with no timeout.
REQ-020 SHALL, on the response handshake (RESP and resp_ready = 1), go to IDLE and increment op_count by 1; op_count wraps from 16'hFFFF to 0.
REQ-021 SHALL ignore input changes on req_a, req_b and req_control after acceptance; the response reflects the captured values.
REQ-022 SHALL NOT accept back-to-back: after a handshake at edge M, req_ready = 1 after edge M, so the next request is accepted at edge M+1 at the earliest.
REQ-023 SHALL ignore req_valid while in EXEC or RESP, with no queuing.
REQ-024 SHALL ignore resp_ready while not in RESP.
REQ-025 SHALL compute SLT with signed compare, including the overflow case: A = 32'h80000000, B = 1 -> 1.

Reset
REQ-026 SHALL, when rst_n = 0, immediately set: state = IDLE; req_ready = 1; resp_valid = 0; resp_result = 0; resp_zero = 0; resp_err = 0; op_count = 0; captured operands = 0.
REQ-027 SHALL, on reset asserted in EXEC or RESP, discard the in-flight operation without counting it; no response appears after release.
REQ-028 SHALL, after rst_n rises, accept a request on the first following edge where req_valid = 1.

Verification
REQ-029 SHALL cover the full ALUOp sweep: A = 32'hA, B = 32'h7, resp_ready = 1, codes 011, 100, 010, 111, 110, 001, 000 -> results 32'hD, 32'hFFFFFFF0, 32'h11, 0 (zero = 1), 32'h3, 32'hF, 32'h2; op_count = 7.
REQ-030 SHALL cover backpressure: ADD with A = 32'hFFFFFFFF, B = 1, resp_ready held 0 for 5 cycles -> result 0, zero = 1, values stable for those 5 cycles, req_ready = 0 throughout, op_count unchanged until resp_ready = 1.
REQ-031 SHALL cover the illegal code: control 101 -> resp_err = 1, result 0, zero = 1; the next legal op returns resp_err = 0.
REQ-032 SHALL cover signed SLT: A = 32'hFFFFFFFF (-1), B = 0 -> 1; A = 0, B = 32'hFFFFFFFF -> 0.
REQ-033 SHALL cover mid-operation reset: rst_n pulsed low while in RESP -> resp_valid = 0 and op_count = 0 immediately; after release, a SUB with A = 5, B = 5 -> result 0, zero = 1, op_count = 1.
REQ-034 SHALL cover input hold: req_a changed in the cycle after acceptance -> the result uses the original value; req_valid high during RESP is not accepted until IDLE.
